// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit: PC width, FSM states,
// queue entry layout and the mispredict compare.
package branch_resolve_unit_pkg;

  localparam int WIDTH_PC = 32;
  localparam logic [WIDTH_PC-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    BRU_RUN   = 1'b0,
    BRU_FLUSH = 1'b1
  } bru_state_t;

  typedef struct packed {
    logic [WIDTH_PC-1:0] pc;
    logic                jump;
    logic [WIDTH_PC-1:0] target;
  } pred_entry_t;

  // A taken prediction that resolves taken can still be wrong if it went to the wrong place.
  function automatic logic is_wrong(input pred_entry_t e, input logic taken,
                                    input logic [WIDTH_PC-1:0] tgt);
    return (e.jump != taken) | (taken & e.jump & (e.target != tgt));
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bundle of fetch-side prediction, execute-side resolution and predictor/fetch feedback.
// master = the pipeline driving predictions/outcomes, slave = the resolve unit.
interface branch_resolve_unit_if;
  import branch_resolve_unit_pkg::*;

  logic                pred_valid;
  logic [WIDTH_PC-1:0] pred_pc;
  logic                pred_hit;
  logic                pred_jump;
  logic [WIDTH_PC-1:0] pred_target;
  logic                pred_ready;
  logic                ex_valid;
  logic                ex_taken;
  logic [WIDTH_PC-1:0] ex_target;
  logic                upd_valid;
  logic                upd_wrong;
  logic [WIDTH_PC-1:0] upd_pc;
  logic [WIDTH_PC-1:0] upd_target;
  logic                flush;
  logic                redirect;
  logic [WIDTH_PC-1:0] redirect_pc;

  modport master (
    output pred_valid, pred_pc, pred_hit, pred_jump, pred_target,
    output ex_valid, ex_taken, ex_target,
    input  pred_ready, upd_valid, upd_wrong, upd_pc, upd_target,
    input  flush, redirect, redirect_pc
  );

  modport slave (
    input  pred_valid, pred_pc, pred_hit, pred_jump, pred_target,
    input  ex_valid, ex_taken, ex_target,
    output pred_ready, upd_valid, upd_wrong, upd_pc, upd_target,
    output flush, redirect, redirect_pc
  );

endinterface

// File: rtl/branch_resolve_unit_pred_queue.sv
// In-order circular FIFO of outstanding predictions; clear wins over push/pop.
module branch_resolve_unit_pred_queue
  import branch_resolve_unit_pkg::*;
#(
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_QW = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic        i_clear,
  input  pred_entry_t i_data,
  output pred_entry_t o_head,
  output logic        o_full,
  output logic        o_empty
);

  pred_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_QW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_QW'(i_push) - CNT_QW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_QW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks execute-stage branch outcomes against queued fetch predictions, trains the
// predictor and redirects/flushes fetch on a mispredict.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_resolve_unit_if.slave bus,
  output logic [CNT_W-1:0]    miss_cnt,
  output logic                q_err
);

  localparam int FC_W = $clog2(FLUSH_CYC + 1);

  bru_state_t          r_state;
  logic [FC_W-1:0]     r_flush_cnt;
  logic                r_upd_valid;
  logic                r_upd_wrong;
  logic [WIDTH_PC-1:0] r_upd_pc;
  logic [WIDTH_PC-1:0] r_upd_target;
  logic                r_redirect;
  logic [WIDTH_PC-1:0] r_redirect_pc;
  logic [CNT_W-1:0]    r_miss_cnt;
  logic                r_q_err;

  pred_entry_t w_head;
  pred_entry_t w_new;
  logic        w_full;
  logic        w_empty;
  logic        w_run;
  logic        w_resolve;
  logic        w_wrong;
  logic        w_mispredict;
  logic        w_push;

  assign w_run        = (r_state == BRU_RUN);
  assign w_resolve    = w_run & bus.ex_valid & ~w_empty;
  assign w_wrong      = is_wrong(w_head, bus.ex_taken, bus.ex_target);
  assign w_mispredict = w_resolve & w_wrong;
  // A pop frees a slot in the same cycle, so a full queue may still take a push then;
  // a push alongside a mispredict is younger than the branch and is dropped.
  assign w_push = w_run & bus.pred_valid & (~w_full | w_resolve) & ~w_mispredict;

  assign w_new.pc     = bus.pred_pc;
  assign w_new.jump   = bus.pred_hit & bus.pred_jump;
  assign w_new.target = bus.pred_target;

  branch_resolve_unit_pred_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_resolve & ~w_wrong),
    .i_clear (w_mispredict),
    .i_data  (w_new),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BRU_RUN;
      r_flush_cnt   <= '0;
      r_upd_valid   <= 1'b0;
      r_upd_wrong   <= 1'b0;
      r_upd_pc      <= '0;
      r_upd_target  <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_miss_cnt    <= '0;
      r_q_err       <= 1'b0;
    end else begin
      r_upd_valid <= w_resolve;
      r_upd_wrong <= w_mispredict;
      r_redirect  <= w_mispredict;
      if (w_resolve) begin
        r_upd_pc      <= w_head.pc;
        r_upd_target  <= bus.ex_target;
        r_redirect_pc <= bus.ex_taken ? bus.ex_target : w_head.pc + PC_STEP;
      end
      if (w_run && bus.ex_valid && w_empty) r_q_err <= 1'b1;
      if (w_mispredict && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      case (r_state)
        BRU_RUN: begin
          if (w_mispredict) begin
            r_state     <= BRU_FLUSH;
            r_flush_cnt <= FC_W'(FLUSH_CYC);
          end
        end
        BRU_FLUSH: begin
          if (r_flush_cnt == FC_W'(1)) r_state <= BRU_RUN;
          r_flush_cnt <= r_flush_cnt - FC_W'(1);
        end
        default: r_state <= BRU_RUN;
      endcase
    end
  end

  assign bus.pred_ready  = w_run & ~w_full;
  assign bus.flush       = (r_state == BRU_FLUSH);
  assign bus.upd_valid   = r_upd_valid;
  assign bus.upd_wrong   = r_upd_wrong;
  assign bus.upd_pc      = r_upd_pc;
  assign bus.upd_target  = r_upd_target;
  assign bus.redirect    = r_redirect;
  assign bus.redirect_pc = r_redirect_pc;
  assign miss_cnt        = r_miss_cnt;
  assign q_err           = r_q_err;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: reset, correct/wrong resolves, flush window,
// full queue with pointer wrap, and asynchronous reset during a flush.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] miss_cnt;
  logic        q_err;
  int          n_cmp = 0;
  int          n_mis = 0;

  branch_resolve_unit_if bus();

  branch_resolve_unit #(.DEPTH(4), .FLUSH_CYC(2), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .miss_cnt (miss_cnt),
    .q_err    (q_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pred_valid  = 1'b0;
    bus.pred_pc     = '0;
    bus.pred_hit    = 1'b0;
    bus.pred_jump   = 1'b0;
    bus.pred_target = '0;
    bus.ex_valid    = 1'b0;
    bus.ex_taken    = 1'b0;
    bus.ex_target   = '0;
  endtask

  task automatic set_pred(input logic [31:0] pc, input logic hit, input logic jump,
                          input logic [31:0] tgt);
    bus.pred_valid  = 1'b1;
    bus.pred_pc     = pc;
    bus.pred_hit    = hit;
    bus.pred_jump   = jump;
    bus.pred_target = tgt;
  endtask

  task automatic set_ex(input logic taken, input logic [31:0] tgt);
    bus.ex_valid  = 1'b1;
    bus.ex_taken  = taken;
    bus.ex_target = tgt;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    step();
    step();
    n_cmp++; if ({bus.upd_valid, bus.upd_wrong, bus.redirect, bus.flush, q_err} !== 5'b0) begin
      n_mis++; $display("FAIL reset_strobes got=%b want=00000",
                        {bus.upd_valid, bus.upd_wrong, bus.redirect, bus.flush, q_err}); end
    n_cmp++; if ({bus.upd_pc, bus.upd_target, bus.redirect_pc, miss_cnt} !== '0) begin
      n_mis++; $display("FAIL reset_buses pc=%h tgt=%h rpc=%h cnt=%0d", bus.upd_pc,
                        bus.upd_target, bus.redirect_pc, miss_cnt); end
    n_cmp++; if (bus.pred_ready !== 1'b1) begin
      n_mis++; $display("FAIL reset_ready got=%b want=1", bus.pred_ready); end
    rst_n = 1'b1;
    set_ex(1'b1, 32'h10);
    step();
    idle();
    n_cmp++; if (q_err !== 1'b1 || bus.upd_valid !== 1'b0) begin
      n_mis++; $display("FAIL empty_resolve q_err=%b upd_valid=%b want 1/0", q_err, bus.upd_valid); end
    step();
    n_cmp++; if (q_err !== 1'b1) begin
      n_mis++; $display("FAIL q_err_sticky got=%b want=1", q_err); end
    $display("test_reset done");
  endtask

  task automatic test_correct_taken();
    apply_reset();
    set_pred(32'h100, 1'b1, 1'b1, 32'h200);
    step();
    idle();
    set_ex(1'b1, 32'h200);
    step();
    idle();
    n_cmp++; if (bus.upd_valid !== 1'b1 || bus.upd_wrong !== 1'b0) begin
      n_mis++; $display("FAIL taken_ok_strobe valid=%b wrong=%b want 1/0", bus.upd_valid, bus.upd_wrong); end
    n_cmp++; if (bus.upd_pc !== 32'h100 || bus.upd_target !== 32'h200) begin
      n_mis++; $display("FAIL taken_ok_data pc=%h tgt=%h want 100/200", bus.upd_pc, bus.upd_target); end
    n_cmp++; if (bus.redirect !== 1'b0 || bus.flush !== 1'b0 || miss_cnt !== 16'd0) begin
      n_mis++; $display("FAIL taken_ok_noredir redir=%b flush=%b cnt=%0d want 0/0/0",
                        bus.redirect, bus.flush, miss_cnt); end
    step();
    n_cmp++; if (bus.upd_valid !== 1'b0) begin
      n_mis++; $display("FAIL upd_pulse got=%b want=0", bus.upd_valid); end
    $display("test_correct_taken done");
  endtask

  task automatic test_miss_taken();
    set_pred(32'h40, 1'b0, 1'b1, 32'h999);
    step();
    idle();
    set_ex(1'b1, 32'h80);
    step();
    idle();
    n_cmp++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h80) begin
      n_mis++; $display("FAIL miss_redirect redir=%b rpc=%h want 1/80", bus.redirect, bus.redirect_pc); end
    n_cmp++; if (bus.upd_valid !== 1'b1 || bus.upd_wrong !== 1'b1 || bus.upd_pc !== 32'h40) begin
      n_mis++; $display("FAIL miss_upd valid=%b wrong=%b pc=%h want 1/1/40",
                        bus.upd_valid, bus.upd_wrong, bus.upd_pc); end
    n_cmp++; if (bus.flush !== 1'b1 || miss_cnt !== 16'd1 || bus.pred_ready !== 1'b0) begin
      n_mis++; $display("FAIL miss_flush1 flush=%b cnt=%0d ready=%b want 1/1/0",
                        bus.flush, miss_cnt, bus.pred_ready); end
    step();
    n_cmp++; if (bus.flush !== 1'b1 || bus.redirect !== 1'b0) begin
      n_mis++; $display("FAIL miss_flush2 flush=%b redir=%b want 1/0", bus.flush, bus.redirect); end
    step();
    n_cmp++; if (bus.flush !== 1'b0 || bus.pred_ready !== 1'b1) begin
      n_mis++; $display("FAIL miss_flush_end flush=%b ready=%b want 0/1", bus.flush, bus.pred_ready); end
    $display("test_miss_taken done");
  endtask

  task automatic test_wrong_taken();
    set_pred(32'h300, 1'b1, 1'b1, 32'h400); step();
    set_pred(32'h304, 1'b1, 1'b0, 32'h0);   step();
    set_pred(32'h308, 1'b1, 1'b0, 32'h0);   step();
    idle();
    set_ex(1'b0, 32'h0);
    step();
    n_cmp++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h304 || miss_cnt !== 16'd2) begin
      n_mis++; $display("FAIL wrong_taken redir=%b rpc=%h cnt=%0d want 1/304/2",
                        bus.redirect, bus.redirect_pc, miss_cnt); end
    for (int i = 0; i < 2; i++) begin
      set_ex(1'b1, 32'hABC);
      step();
      n_cmp++; if (bus.upd_valid !== 1'b0 || q_err !== 1'b0) begin
        n_mis++; $display("FAIL flush_ignores_ex cyc=%0d valid=%b q_err=%b want 0/0",
                          i, bus.upd_valid, q_err); end
    end
    idle();
    set_pred(32'h500, 1'b1, 1'b0, 32'h0);
    step();
    idle();
    set_ex(1'b0, 32'h0);
    step();
    idle();
    n_cmp++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'h500 || bus.upd_wrong !== 1'b0) begin
      n_mis++; $display("FAIL queue_cleared valid=%b pc=%h wrong=%b want 1/500/0",
                        bus.upd_valid, bus.upd_pc, bus.upd_wrong); end
    $display("test_wrong_taken done");
  endtask

  task automatic test_full_wrap();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h20; exp_pc[1] = 32'h30; exp_pc[2] = 32'h40; exp_pc[3] = 32'h60;
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      set_pred(32'(i * 16), 1'b1, 1'b0, 32'h0);
      step();
    end
    idle();
    n_cmp++; if (bus.pred_ready !== 1'b0) begin
      n_mis++; $display("FAIL full_ready got=%b want=0", bus.pred_ready); end
    set_pred(32'h50, 1'b1, 1'b0, 32'h0);
    step();
    set_pred(32'h60, 1'b1, 1'b0, 32'h0);
    set_ex(1'b0, 32'h0);
    step();
    idle();
    n_cmp++; if (bus.upd_pc !== 32'h10 || bus.upd_wrong !== 1'b0 || bus.pred_ready !== 1'b0) begin
      n_mis++; $display("FAIL full_push_pop pc=%h wrong=%b ready=%b want 10/0/0",
                        bus.upd_pc, bus.upd_wrong, bus.pred_ready); end
    for (int i = 0; i < 4; i++) begin
      set_ex(1'b0, 32'h0);
      step();
      idle();
      n_cmp++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== exp_pc[i] || bus.upd_wrong !== 1'b0) begin
        n_mis++; $display("FAIL wrap_order idx=%0d valid=%b pc=%h want 1/%h",
                          i, bus.upd_valid, bus.upd_pc, exp_pc[i]); end
    end
    n_cmp++; if (bus.pred_ready !== 1'b1 || q_err !== 1'b0) begin
      n_mis++; $display("FAIL drained ready=%b q_err=%b want 1/0", bus.pred_ready, q_err); end
    $display("test_full_wrap done");
  endtask

  task automatic test_async_reset();
    set_pred(32'h700, 1'b1, 1'b1, 32'h800);
    step();
    idle();
    set_ex(1'b0, 32'h0);
    step();
    idle();
    n_cmp++; if (bus.flush !== 1'b1 || miss_cnt !== 16'd1) begin
      n_mis++; $display("FAIL pre_reset_flush flush=%b cnt=%0d want 1/1", bus.flush, miss_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.flush !== 1'b0 || miss_cnt !== 16'd0 || bus.redirect !== 1'b0) begin
      n_mis++; $display("FAIL async_reset flush=%b cnt=%0d redir=%b want 0/0/0",
                        bus.flush, miss_cnt, bus.redirect); end
    n_cmp++; if (bus.pred_ready !== 1'b1 || bus.upd_valid !== 1'b0) begin
      n_mis++; $display("FAIL async_reset_ready ready=%b valid=%b want 1/0", bus.pred_ready, bus.upd_valid); end
    #1;
    rst_n = 1'b1;
    set_ex(1'b1, 32'h0);
    step();
    idle();
    n_cmp++; if (q_err !== 1'b1 || bus.upd_valid !== 1'b0) begin
      n_mis++; $display("FAIL reset_queue_empty q_err=%b valid=%b want 1/0", q_err, bus.upd_valid); end
    $display("test_async_reset done");
  endtask

  initial begin
    idle();
    test_reset();
    test_correct_taken();
    test_miss_taken();
    test_wrong_taken();
    test_full_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
